// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the LCD_CTRL command scheduler: opcode values,
// scheduler state encoding and an opcode legality helper.
package lcd_ctrl_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] WRITE       = 4'h0;
  localparam logic [OPC_W-1:0] SHIFT_UP    = 4'h1;
  localparam logic [OPC_W-1:0] SHIFT_DOWN  = 4'h2;
  localparam logic [OPC_W-1:0] SHIFT_LEFT  = 4'h3;
  localparam logic [OPC_W-1:0] SHIFT_RIGHT = 4'h4;
  localparam logic [OPC_W-1:0] MAX         = 4'h5;
  localparam logic [OPC_W-1:0] MIN         = 4'h6;
  localparam logic [OPC_W-1:0] AVERAGE     = 4'h7;
  localparam logic [OPC_W-1:0] ROT_CCW     = 4'h8;
  localparam logic [OPC_W-1:0] ROT_CW      = 4'h9;
  localparam logic [OPC_W-1:0] MIRROR_X    = 4'hA;
  localparam logic [OPC_W-1:0] MIRROR_Y    = 4'hB;
  localparam logic [OPC_W-1:0] OPC_MAX     = 4'hB;

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_FINISH  = 3'd6
  } sched_state_t;

  function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
    return (opc <= OPC_MAX);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small opcode FIFO with registered occupancy; head is read combinationally
// from storage, so a pushed entry becomes visible one cycle after the push.
module lcd_cmd_fifo
  import lcd_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [OPC_W-1:0]         push_data,
  input  logic                     pop,
  output logic [OPC_W-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [OPC_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (level_r == LVL_FULL);
  assign empty     = (level_r == '0);
  assign level     = level_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage is not reset; pointers and level alone define the valid contents.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// Issues buffered host opcodes to the LCD_CTRL engine one at a time, following
// the engine's busy handshake; Write is terminal and waits for lcd_done.
module lcd_cmd_scheduler
  import lcd_ctrl_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [OPC_W-1:0]         host_cmd,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic                     lcd_busy,
  input  logic                     lcd_done,
  output logic [OPC_W-1:0]         cmd,
  output logic                     cmd_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               issued_cnt,
  output logic                     finished,
  output logic                     err_timeout,
  output logic                     err_illegal
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  sched_state_t     state_r;
  logic             locked_r;
  logic             is_write_r;
  logic [TW-1:0]    timer_r;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic [OPC_W-1:0] head_s;

  assign host_ready = !full_s && !locked_r;
  assign push_s     = host_valid && host_ready;
  assign pop_s      = (state_r == ST_IDLE) && !empty_s && !lcd_busy;

  lcd_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (host_cmd),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (fifo_level)
  );

  // Scheduler FSM with its timer, counters and sticky status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_BOOT;
      locked_r    <= 1'b0;
      is_write_r  <= 1'b0;
      timer_r     <= '0;
      cmd         <= '0;
      cmd_valid   <= 1'b0;
      issued_cnt  <= 8'd0;
      finished    <= 1'b0;
      err_timeout <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      if (push_s && (host_cmd == WRITE)) begin
        locked_r <= 1'b1;
      end
      cmd_valid <= 1'b0;
      case (state_r)
        ST_BOOT: begin
          if (!lcd_busy) begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (pop_s) begin
            if (opc_legal(head_s)) begin
              cmd        <= head_s;
              cmd_valid  <= 1'b1;
              is_write_r <= (head_s == WRITE);
              state_r    <= ST_ISSUE;
            end else begin
              err_illegal <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          issued_cnt <= issued_cnt + 8'd1;
          timer_r    <= '0;
          state_r    <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          // An engine that never acknowledges must not stall the queue forever.
          if (lcd_busy) begin
            state_r <= ST_WAIT_LO;
          end else if (timer_r == TMR_LAST) begin
            err_timeout <= 1'b1;
            state_r     <= is_write_r ? ST_DRAIN : ST_IDLE;
          end else begin
            timer_r <= timer_r + TMR_ONE;
          end
        end
        ST_WAIT_LO: begin
          if (!lcd_busy) begin
            state_r <= is_write_r ? ST_DRAIN : ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (lcd_done) begin
            finished <= 1'b1;
            state_r  <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state_r <= ST_FINISH;
        end
        default: begin
          state_r <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a timing-rule model.
module tb_lcd_cmd_scheduler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    host_cmd = 4'h0;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic          lcd_busy = 1'b1;
  logic          lcd_done = 1'b0;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [LW-1:0] fifo_level;
  logic [7:0]    issued_cnt;
  logic          finished;
  logic          err_timeout;
  logic          err_illegal;

  always #5 clk = ~clk;

  lcd_cmd_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_valid(host_valid),
    .host_ready(host_ready), .lcd_busy(lcd_busy), .lcd_done(lcd_done),
    .cmd(cmd), .cmd_valid(cmd_valid), .fifo_level(fifo_level),
    .issued_cnt(issued_cnt), .finished(finished),
    .err_timeout(err_timeout), .err_illegal(err_illegal)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a queue of accepted opcodes plus the elapsed-time rules
  // of one outstanding command (age 0 = strobe cycle).
  logic [3:0] mq[$];
  bit         m_locked, m_boot, m_out, m_hi, m_wr, m_drain;
  int         m_age;
  logic [3:0] e_cmd;
  logic [7:0] e_cnt;
  bit         e_valid, e_fin, e_tmo, e_ill;

  always @(posedge clk) begin : model_b
    bit acc;
    logic [3:0] op;
    if (!reset) begin
      mq.delete();
      m_locked = 0; m_boot = 1; m_out = 0; m_hi = 0; m_wr = 0; m_drain = 0; m_age = 0;
      e_cmd = 4'h0; e_cnt = 8'd0; e_valid = 0; e_fin = 0; e_tmo = 0; e_ill = 0;
    end else begin
      acc = host_valid && (mq.size() < DEPTH) && !m_locked;
      e_valid = 0;
      if (m_boot) begin
        if (!lcd_busy) m_boot = 0;
      end else if (e_fin) begin
        m_out = 0;
      end else if (m_drain) begin
        if (lcd_done) e_fin = 1;
      end else if (m_out) begin
        m_age++;
        if (m_age == 0) e_cnt = e_cnt + 8'd1;
        else if (!m_hi) begin
          if (lcd_busy) m_hi = 1;
          else if (m_age == TIMEOUT) begin e_tmo = 1; m_out = 0; m_drain = m_wr; end
        end else if (!lcd_busy) begin
          m_out = 0; m_drain = m_wr;
        end
      end else if (mq.size() > 0 && !lcd_busy) begin
        op = mq.pop_front();
        if (op > 4'hB) e_ill = 1;
        else begin
          e_cmd = op; e_valid = 1; m_out = 1; m_hi = 0; m_wr = (op == 4'h0); m_age = -1;
        end
      end
      if (acc) begin
        mq.push_back(host_cmd);
        if (host_cmd == 4'h0) m_locked = 1;
      end
    end
  end

  int         s_cyc[$];
  logic [3:0] s_cmd[$];

  // Single compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("host_ready",  host_ready,  (!m_locked && mq.size() < DEPTH));
      chk("fifo_level",  fifo_level,  mq.size());
      chk("cmd",         cmd,         e_cmd);
      chk("cmd_valid",   cmd_valid,   e_valid);
      chk("issued_cnt",  issued_cnt,  e_cnt);
      chk("finished",    finished,    e_fin);
      chk("err_timeout", err_timeout, e_tmo);
      chk("err_illegal", err_illegal, e_ill);
      if (cmd_valid === 1'b1) begin
        s_cyc.push_back(cyc);
        s_cmd.push_back(cmd);
      end
    end
  end

  // Engine model: 0 random handshake (occasionally ignores), 1 ignore,
  // 2 held busy, 3 busy exactly one cycle, one cycle after the strobe.
  int eng_mode = 2;
  bit done_force = 0, done_rand = 0;
  int b_from = -10, b_to = -10;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1 && eng_mode == 3) begin
      b_from = cyc + 1; b_to = cyc + 1;
    end else if (cmd_valid === 1'b1 && eng_mode == 0 && $urandom_range(0, 7) != 0) begin
      b_from = cyc + $urandom_range(1, 3);
      b_to   = b_from + $urandom_range(0, 2);
    end
    case (eng_mode)
      1:       lcd_busy = 1'b0;
      2:       lcd_busy = 1'b1;
      default: lcd_busy = (cyc >= b_from && cyc <= b_to);
    endcase
    lcd_done = done_force || (done_rand && $urandom_range(0, 7) == 0);
  end

  function automatic logic [3:0] scmd(input int i);
    if (i < s_cmd.size()) return s_cmd[i];
    return 4'bxxxx;
  endfunction

  function automatic int scyc(input int i);
    if (i < s_cyc.size()) return s_cyc[i];
    return -1000;
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk); #1;
    reset = 1'b0; host_valid = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    reset = 1'b1;
    chk_en = 1'b1;
    s_cyc.delete(); s_cmd.delete();
  endtask

  task automatic push(input logic [3:0] op, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk); #1;
      host_cmd = op; host_valid = 1'b1;
      ok = host_ready;
    end
  endtask

  task automatic host_idle();
    @(negedge clk); #1;
    host_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int bound);
    for (int i = 0; i < bound && s_cmd.size() < n; i++) begin
      @(negedge clk); #1;
    end
    chk("strobe_count", s_cmd.size(), n);
  endtask

  initial begin
    bit ok;
    int s0, t_err;
    logic [3:0] list[6];

    // Reset state and boot gating (engine busy for ~70 cycles).
    eng_mode = 2;
    do_reset(2);
    chk("rst_host_ready", host_ready, 1);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_flags", {finished, err_timeout, err_illegal}, 0);
    push(4'h1, 4, ok); chk("boot_push1", ok, 1);
    push(4'h5, 4, ok); chk("boot_push5", ok, 1);
    host_idle();
    repeat (67) @(negedge clk);
    #1;
    chk("boot_no_strobe", s_cmd.size(), 0);
    eng_mode = 3;
    wait_strobes(2, 40);
    chk("boot_cmd0", scmd(0), 4'h1);
    chk("boot_cmd1", scmd(1), 4'h5);
    repeat (4) @(negedge clk);
    #1;
    chk("boot_issued", issued_cnt, 2);

    // Full FIFO with the engine held busy, then drain in order.
    eng_mode = 2;
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      push(4'(i + 1), 4, ok); chk("full_acc", ok, 1);
    end
    host_idle();
    chk("full_ready", host_ready, 0);
    chk("full_level", fifo_level, 4);
    push(4'h5, 5, ok); chk("full_reject", ok, 0);
    eng_mode = 3;
    push(4'h5, 20, ok); chk("full_acc5", ok, 1);
    chk("acc_after_pop", s_cmd.size(), 1);
    push(4'h6, 20, ok); chk("full_acc6", ok, 1);
    host_idle();
    wait_strobes(6, 80);
    for (int i = 0; i < 6; i++) chk("drain_order", scmd(i), 4'(i + 1));

    // Four-cycle issue spacing against the one-cycle engine handshake.
    do_reset(2);
    list[0] = 4'h3; list[1] = 4'h9; list[2] = 4'hA;
    for (int i = 0; i < 3; i++) begin
      push(list[i], 4, ok); chk("sp_push", ok, 1);
    end
    host_idle();
    wait_strobes(3, 40);
    for (int i = 0; i < 3; i++) chk("sp_cmd", scmd(i), list[i]);
    chk("sp_gap1", scyc(1) - scyc(0), 4);
    chk("sp_gap2", scyc(2) - scyc(1), 4);

    // Illegal opcode is discarded and flagged.
    do_reset(1);
    push(4'hE, 4, ok);
    push(4'h2, 4, ok);
    host_idle();
    wait_strobes(1, 30);
    repeat (6) @(negedge clk);
    #1;
    chk("ill_flag", err_illegal, 1);
    chk("ill_strobes", s_cmd.size(), 1);
    chk("ill_cmd", scmd(0), 4'h2);
    chk("ill_issued", issued_cnt, 1);

    // Timeout: engine ignores strobes.
    eng_mode = 1;
    do_reset(2);
    push(4'h6, 4, ok);
    push(4'h8, 4, ok);
    host_idle();
    wait_strobes(1, 20);
    s0 = scyc(0);
    t_err = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (err_timeout === 1'b1 && t_err < 0) t_err = cyc;
    end
    chk("tmo_cycle", t_err, s0 + 1 + TIMEOUT);
    wait_strobes(2, 10);
    chk("tmo_next_cyc", scyc(1), s0 + 2 + TIMEOUT);
    chk("tmo_next_cmd", scmd(1), 4'h8);

    // Terminal Write, done, then reset clears the sticky state.
    eng_mode = 3;
    do_reset(2);
    push(4'h7, 4, ok); chk("wr_push7", ok, 1);
    push(4'h0, 4, ok); chk("wr_push0", ok, 1);
    host_idle();
    chk("wr_locked", host_ready, 0);
    push(4'h4, 5, ok); chk("wr_reject4", ok, 0);
    host_idle();
    wait_strobes(2, 30);
    chk("wr_cmd", scmd(1), 4'h0);
    repeat (8) @(negedge clk);
    #1;
    chk("wr_not_fin", finished, 0);
    done_force = 1'b1;
    @(negedge clk); #1;
    done_force = 1'b0;
    chk("wr_fin_same", finished, 0);
    @(negedge clk); #1;
    chk("wr_fin_next", finished, 1);
    do_reset(1);
    chk("wr_rst_fin", finished, 0);
    chk("wr_rst_ready", host_ready, 1);

    // Randomized traffic; round 0 has no Write and runs long enough to wrap issued_cnt.
    done_rand = 1'b1;
    for (int r = 0; r < 5; r++) begin
      eng_mode = (r == 0) ? 3 : 0;
      do_reset(1 + r % 2);
      for (int i = 0; i < ((r == 0) ? 2500 : 400); i++) begin
        @(negedge clk); #1;
        host_valid = 1'($urandom_range(0, 1));
        host_cmd = 4'($urandom_range(0, 15));
        if (host_cmd == 4'h0 && (r == 0 || $urandom_range(0, 15) != 0)) host_cmd = 4'h1;
      end
    end
    host_valid = 1'b0;
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_scheduler.md
Name: lcd_cmd_scheduler

Overview:
- Sequences commands into the LCD_CTRL image-processing engine.
- Buffers host commands in a small FIFO and issues each one as a single-cycle cmd/cmd_valid pulse.
- Tracks the engine's busy handshake so that only one command is outstanding at a time.
- Treats Write (4'h0) as the terminal command: after Write it waits for the engine's done and reports completion.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TIMEOUT, 16, max cycles to wait for lcd_busy to rise after an issue.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- host_cmd  in  4  command opcode from host.
- host_valid  in  1  host offers host_cmd.
- host_ready  out  1  scheduler accepts; push = host_valid && host_ready.
- lcd_busy  in  1  engine busy.
- lcd_done  in  1  engine finished image write-back.
- cmd  out  4  opcode to engine.
- cmd_valid  out  1  one-cycle issue strobe.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- issued_cnt  out  8  commands issued, wraps 255->0.
- finished  out  1  sticky; engine done after Write.
- err_timeout  out  1  sticky; busy never rose after an issue.
- err_illegal  out  1  sticky; opcode > 4'hB was popped.

Behaviour:
- Reset (reset==0 at an edge):
  - state=BOOT, FIFO flushed, locked=0.
  - All outputs 0 except host_ready; host_ready=1 in BOOT when the FIFO is not full.
  - Reset mid-operation aborts any in-flight issue; the engine is reset by its own reset.
- FIFO:
  - host_ready = !full && !locked, from registered state.
  - A push while a pop occurs on a full FIFO is not possible (ready is low when full).
  - Push and pop in the same cycle with 1 <= level < DEPTH: level unchanged.
  - No bypass: a push into an empty FIFO is issued at the earliest one cycle later.
  - Accepting Write (4'h0) sets locked; host_ready stays 0 until reset.
- States:
  - BOOT: wait for lcd_busy==0 (engine image load done), then go to IDLE. Pushes are allowed.
  - IDLE: if !empty && !lcd_busy, pop the head.
    - Opcode <= 4'hB: register cmd=opcode, cmd_valid=1 at the same edge, go to ISSUE.
    - Opcode > 4'hB: discard, set err_illegal, stay in IDLE. No strobe, issued_cnt unchanged.
  - ISSUE: cmd_valid=1 for exactly this cycle; cmd is held. issued_cnt++ at the exit edge. Go to WAIT_HI; the timer is cleared.
  - WAIT_HI: wait for lcd_busy==1, then go to WAIT_LO.
    - The timer counts cycles in WAIT_HI.
    - If the timer reaches TIMEOUT with busy still 0: set err_timeout and go to IDLE (or DRAIN if the opcode was Write).
  - WAIT_LO: wait for lcd_busy==0.
    - If the issued opcode was Write, go to DRAIN; otherwise go to IDLE.
  - DRAIN: wait for lcd_done==1, then go to FINISH.
  - FINISH: finished=1 (sticky). No further issues. Terminal until reset.
- Outputs:
  - cmd holds its last value outside ISSUE; reset value 0.
  - cmd_valid is never high for two consecutive cycles.
  - Minimum issue-to-issue spacing is 4 cycles.
- Latency: condition true in IDLE at cycle t gives cmd_valid high in cycle t+1.
- Counter: issued_cnt is 8-bit and wraps modulo 256.

Decomposition:
- Package lcd_ctrl_pkg:
  - 4-bit opcode constants: WRITE=0, SHIFT_UP..MIRROR_Y=1..B, OPC_MAX=4'hB.
  - Scheduler state encoding: BOOT, IDLE, ISSUE, WAIT_HI, WAIT_LO, DRAIN, FINISH.
- One sub-module, lcd_cmd_fifo: parameterised DEPTH, synchronous active-low reset, outputs full/empty/level.
- FSM, timer and counters live in lcd_cmd_scheduler.

Test Plan:
- Boot gating: lcd_busy=1 for 70 cycles after reset, host pushes 4'h1, 4'h5 -> no cmd_valid while busy=1. After busy falls: cmd=1 strobe, then cmd=5 strobe. issued_cnt=2.
- Full FIFO: DEPTH=4, engine model held busy, host pushes 6 cmds -> host_ready=0 after 4 accepted, fifo_level=4. Releasing busy drains in order. The 5th cmd is accepted only after the first pop.
- Engine-model handshake: busy rises 1 cycle after a strobe and falls 1 cycle later; push 4'h3,4'h9,4'hA -> three strobes exactly 4 cycles apart, cmd values 3, 9, A.
- Illegal opcode: push 4'hE then 4'h2 -> 4'hE is never driven on cmd, err_illegal=1. cmd=2 is strobed, issued_cnt=1.
- Timeout: engine ignores the strobe (busy stays 0) -> err_timeout=1 exactly TIMEOUT=16 cycles into WAIT_HI. The next queued cmd is issued afterwards.
- Terminal Write: push 4'h7, 4'h0, then 4'h4 -> host_ready=0 after 4'h0 accepted, 4'h4 rejected. After the Write handshake, lcd_done=1 -> finished=1 next cycle. Asserting reset=0 one cycle -> finished=0, host_ready=1.
